// File: rtl/adc_avg_fifo.sv
// Averages 2^LogN ADC samples per result into a first-word-fall-through FIFO; a result
// is visible on avg_o one cycle after the Nth strobe. ADC_AVG_OVF_STICKY_EN makes ovf_o sticky.
module adc_avg_fifo #(
  parameter int LogN     = 2,
  parameter int LogDepth = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [11:0]         sample_i,
  input  logic                sample_vld_i,
  input  logic                clr_i,
  input  logic                rd_i,
  output logic [11:0]         avg_o,
  output logic                empty_o,
  output logic                full_o,
  output logic [LogDepth:0]   level_o,
  output logic                ovf_o
);

  localparam int AccW  = 12 + LogN;
  localparam int LvlW  = LogDepth + 1;
  localparam int Depth = 1 << LogDepth;

  logic [AccW-1:0]     acc_q, acc_d;
  logic [AccW-1:0]     sum;
  logic                last_sample;
  logic [11:0]         result;
  logic                push, pop, drop, wr_en;
  logic [LogDepth-1:0] wr_ptr_q, wr_ptr_d;
  logic [LogDepth-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]     level_q, level_d;
  logic                ovf_q, ovf_d;
  logic [11:0]         mem_q [Depth];

  // Width 12+LogN holds N full-scale samples, so the sum cannot wrap.
  assign sum    = acc_q + AccW'(sample_i);
  assign result = sum[AccW-1:LogN];

  generate
    if (LogN == 0) begin : g_no_cnt
      assign last_sample = 1'b1;
    end else begin : g_cnt
      logic [LogN-1:0] scnt_q, scnt_d;

      assign last_sample = (scnt_q == {LogN{1'b1}});

      // Counter wraps to zero naturally after the Nth sample.
      always_comb begin
        scnt_d = scnt_q;
        if (clr_i) begin
          scnt_d = '0;
        end else if (sample_vld_i) begin
          scnt_d = scnt_q + LogN'(1);
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          scnt_q <= '0;
        end else begin
          scnt_q <= scnt_d;
        end
      end
    end
  endgenerate

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (sample_vld_i) begin
      acc_d = last_sample ? '0 : sum;
    end
  end

  assign empty_o = (level_q == '0);
  assign full_o  = level_q[LogDepth];
  assign level_o = level_q;
  assign avg_o   = empty_o ? 12'h000 : mem_q[rd_ptr_q];
  assign ovf_o   = ovf_q;

  // A pop in the same cycle frees the slot, so a push into a full FIFO only drops without rd_i.
  assign push  = sample_vld_i && last_sample && !clr_i;
  assign pop   = rd_i && !empty_o && !clr_i;
  assign drop  = push && full_o && !pop;
  assign wr_en = push && !drop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + LogDepth'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + LogDepth'(1);
      end
      case ({wr_en, pop})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
`ifdef ADC_AVG_OVF_STICKY_EN
    ovf_d = clr_i ? 1'b0 : (ovf_q | drop);
`else
    ovf_d = clr_i ? 1'b0 : drop;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is left unreset; avg_o is masked while empty.
  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) begin
      mem_q[wr_ptr_q] <= result;
    end
  end

endmodule

// File: tb/tb_adc_avg_fifo.sv
// Self-checking bench for adc_avg_fifo with LogN=2, LogDepth=3.
module tb_adc_avg_fifo;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [11:0] sample_i = '0;
  logic        sample_vld_i = 1'b0;
  logic        clr_i = 1'b0;
  logic        rd_i = 1'b0;
  logic [11:0] avg_o;
  logic        empty_o;
  logic        full_o;
  logic [3:0]  level_o;
  logic        ovf_o;

  adc_avg_fifo #(.LogN(2), .LogDepth(3)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .sample_i     (sample_i),
    .sample_vld_i (sample_vld_i),
    .clr_i        (clr_i),
    .rd_i         (rd_i),
    .avg_o        (avg_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .level_o      (level_o),
    .ovf_o        (ovf_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0][11:0] s;
    logic [11:0]      exp;
    int               gap;
  } vec_t;

  vec_t        vt[5];
  logic [11:0] sb[$];
  int          n_pass = 0;
  int          n_total = 0;

`ifdef ADC_AVG_OVF_STICKY_EN
  localparam logic StickyOvf = 1'b1;
`else
  localparam logic StickyOvf = 1'b0;
`endif

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic strobe(input logic [11:0] v, input logic with_rd);
    sample_i     = v;
    sample_vld_i = 1'b1;
    rd_i         = with_rd;
    tick();
    sample_vld_i = 1'b0;
    rd_i         = 1'b0;
  endtask

  // Four identical samples produce exactly v.
  task automatic push_result(input logic [11:0] v, input logic with_rd);
    for (int k = 0; k < 3; k++) strobe(v, 1'b0);
    strobe(v, with_rd);
  endtask

  task automatic pop_check(input string nm);
    logic [11:0] e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'(empty_o), 32'd0);
    end else begin
      e = sb.pop_front();
      chk(nm, 32'(avg_o), 32'(e));
    end
    rd_i = 1'b1;
    tick();
    rd_i = 1'b0;
  endtask

  initial begin
    vt[0] = '{s: '{12'h401, 12'h300, 12'h200, 12'h100}, exp: 12'h280, gap: 0};
    vt[1] = '{s: '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, exp: 12'hFFF, gap: 1};
    vt[2] = '{s: '{12'h003, 12'h000, 12'h000, 12'h000}, exp: 12'h000, gap: 0};
    vt[3] = '{s: '{12'h004, 12'h003, 12'h002, 12'h001}, exp: 12'h002, gap: 2};
    vt[4] = '{s: '{12'h002, 12'h001, 12'h7FF, 12'h800}, exp: 12'h400, gap: 0};

    tick();
    tick();
    rst_i = 1'b0;
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full",  32'(full_o),  32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_avg",   32'(avg_o),   32'd0);
    chk("rst_ovf",   32'(ovf_o),   32'd0);

    // Table vectors: result visible one cycle after the 4th strobe.
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) begin
        strobe(vt[i].s[j], 1'b0);
        if (j < 3) for (int g = 0; g < vt[i].gap; g++) tick();
      end
      sb.push_back(vt[i].exp);
      chk($sformatf("vec%0d_level", i), 32'(level_o), 32'(i + 1));
      chk($sformatf("vec%0d_empty", i), 32'(empty_o), 32'd0);
      if (i == 0) chk("vec0_head", 32'(avg_o), 32'h280);
    end
    for (int i = 0; i < 5; i++) pop_check($sformatf("vec%0d_pop", i));
    chk("drain_empty", 32'(empty_o), 32'd1);
    chk("drain_avg",   32'(avg_o),   32'd0);

    // Fill to full, then a dropped push.
    for (int k = 1; k <= 8; k++) begin
      push_result(12'(k * 12'h111), 1'b0);
      sb.push_back(12'(k * 12'h111));
    end
    chk("full_flag",  32'(full_o),  32'd1);
    chk("full_level", 32'(level_o), 32'd8);
    chk("full_ovf0",  32'(ovf_o),   32'd0);
    push_result(12'h999, 1'b0);
    chk("drop_ovf",   32'(ovf_o),   32'd1);
    chk("drop_level", 32'(level_o), 32'd8);
    chk("drop_head",  32'(avg_o),   32'(sb[0]));
    tick();
    chk("ovf_after",  32'(ovf_o),   32'(StickyOvf));

    // Push coincident with pop on a full FIFO: no drop.
    push_result(12'hABC, 1'b1);
    void'(sb.pop_front());
    sb.push_back(12'hABC);
    chk("pp_level", 32'(level_o), 32'd8);
    chk("pp_ovf",   32'(ovf_o),   32'(StickyOvf));
    for (int i = 0; i < 8; i++) pop_check($sformatf("full_pop%0d", i));
    chk("full_drain_empty", 32'(empty_o), 32'd1);

    // Reset mid-average discards the partial sum.
    strobe(12'h800, 1'b0);
    strobe(12'h800, 1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst2_ovf", 32'(ovf_o), 32'd0);
    push_result(12'h010, 1'b0);
    sb.push_back(12'h010);
    chk("rst2_level", 32'(level_o), 32'd1);
    pop_check("rst2_pop");

    // Reads on empty are ignored.
    for (int i = 0; i < 3; i++) begin
      rd_i = 1'b1;
      tick();
      chk($sformatf("erd%0d_level", i), 32'(level_o), 32'd0);
      chk($sformatf("erd%0d_empty", i), 32'(empty_o), 32'd1);
      chk($sformatf("erd%0d_avg", i),   32'(avg_o),   32'd0);
    end
    rd_i = 1'b0;

    // clr_i with 3 entries and a partial sum; strobe/read during clr ignored.
    for (int k = 0; k < 3; k++) push_result(12'h055, 1'b0);
    chk("pre_clr_level", 32'(level_o), 32'd3);
    strobe(12'h700, 1'b0);
    strobe(12'h700, 1'b0);
    clr_i = 1'b1;
    strobe(12'h700, 1'b1);
    clr_i = 1'b0;
    chk("clr_empty", 32'(empty_o), 32'd1);
    chk("clr_level", 32'(level_o), 32'd0);
    chk("clr_avg",   32'(avg_o),   32'd0);

    // Push with rd_i on empty: no pop, level becomes 1.
    for (int k = 0; k < 3; k++) strobe(12'h020, 1'b0);
    strobe(12'h020, 1'b1);
    sb.push_back(12'h020);
    chk("er_push_level", 32'(level_o), 32'd1);
    pop_check("er_push_pop");
    chk("final_empty", 32'(empty_o), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adc_avg_fifo.md
ADC_AVG_FIFO -- requirements
Module: adc_avg_fifo

Interface
REQ-001 SHALL have parameter LogN, default 2, meaning log2 of the number of ADC samples averaged per result (N = 2^LogN, legal 0..6).
REQ-002 SHALL have parameter LogDepth, default 3, meaning log2 of the result FIFO depth (default 8 entries).
REQ-003 SHALL have port clk_i, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port sample_i, input, 12 bits: ADC conversion word, driven from the ADC SPI stage dout.
REQ-006 SHALL have port sample_vld_i, input, 1 bit: one-cycle strobe marking sample_i valid (ADC end-of-conversion).
REQ-007 SHALL have port clr_i, input, 1 bit: synchronous flush of the accumulator and FIFO.
REQ-008 SHALL have port rd_i, input, 1 bit: pop request for the FIFO head.
REQ-009 SHALL have port avg_o, output, 12 bits: FIFO head value, first-word-fall-through.
REQ-010 SHALL have port empty_o, output, 1 bit: FIFO holds no entries.
REQ-011 SHALL have port full_o, output, 1 bit: FIFO holds 2^LogDepth entries.
REQ-012 SHALL have port level_o, output, LogDepth+1 bits: current FIFO occupancy.
REQ-013 SHALL have port ovf_o, output, 1 bit: result dropped because FIFO was full.

Function
REQ-014 SHALL hold accumulator acc, width 12+LogN, and sample counter scnt, width LogN (absent when LogN=0).
REQ-015 On sample_vld_i with scnt < N-1: acc <= acc + sample_i, scnt <= scnt + 1.
REQ-016 On sample_vld_i with scnt = N-1: result = (acc + sample_i) >> LogN (truncation, no rounding), acc <= 0, scnt <= 0, result pushed to FIFO in the same edge.
REQ-017 Latency: empty_o SHALL fall and avg_o SHALL show the result one cycle after the clock edge sampling the Nth sample_vld_i (FIFO previously empty).
REQ-018 Arithmetic SHALL never overflow: N samples of 0xFFF average to exactly 0xFFF.
REQ-019 rd_i while empty_o=1 SHALL be ignored; level_o, pointers unchanged.
REQ-020 Push while full_o=1 and rd_i=0: result discarded, FIFO unchanged, ovf_o asserted.
REQ-021 Push and rd_i in the same cycle: both occur; when full, level stays 2^LogDepth with no drop; when empty, no pop occurs and level becomes 1.
REQ-022 Pointers SHALL wrap modulo 2^LogDepth; level_o = writes - reads.
REQ-023 clr_i SHALL zero acc, scnt, pointers, level_o, ovf_o on the next edge; sample_vld_i and rd_i in that cycle ignored.
REQ-024 avg_o SHALL read 0 whenever empty_o=1.

Reset
REQ-025 On rst_i=1 at a clock edge: acc=0, scnt=0, pointers=0, level_o=0, empty_o=1, full_o=0, avg_o=0, ovf_o=0; rst_i has priority over clr_i.
REQ-026 Reset asserted mid-average SHALL discard the partial sum; next average starts fresh from the first sample after reset release.
REQ-027 FIFO storage contents SHALL NOT require reset.

Configuration
REQ-028 Macro ADC_AVG_OVF_STICKY_EN: when defined, ovf_o SHALL be sticky, set on first drop and cleared only by rst_i or clr_i.
REQ-029 Without ADC_AVG_OVF_STICKY_EN, ovf_o SHALL be a one-cycle pulse in the cycle after each dropped result.

Verification
REQ-030 LogN=2; samples 0x100,0x200,0x300,0x401 -> avg_o=0x280 (truncated) one cycle after 4th strobe, empty_o=0, level_o=1.
REQ-031 Four samples of 0xFFF -> avg_o=0xFFF, no wrap.
REQ-032 Fill 8 results, no rd_i, push 9th -> full_o=1, level_o=8, ovf_o asserted (pulse or sticky per macro), head value unchanged.
REQ-033 Full FIFO, 9th push coincident with rd_i -> no drop, ovf_o=0, level_o=8, new tail correct after 8 further pops.
REQ-034 Two samples in, rst_i one cycle, then four samples 0x010 -> single result 0x010, level_o=1.
REQ-035 rd_i on empty FIFO for 3 cycles -> level_o=0, empty_o=1, avg_o=0; then clr_i with 3 entries -> empty next cycle.
